direction_select_ctrl: RTL

Upstream control stage for the direction multiplexer: takes four raw direction pushbuttons (up, right, down, left), synchronises and debounces them, and latches the last pressed direction as a 2-bit select code. That code is driven on select1:select0, which feed the multiplexer's select inputs directly. It is the only source of the multiplexer's selects in the design.

---
 rtl/direction_select_ctrl_pkg.sv | 25 ++
 rtl/direction_select_ctrl_button_debounce.sv | 50 +++++
 rtl/direction_select_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/direction_select_ctrl_pkg.sv
// Shared constants for the direction select controller: direction codes,
// mode encoding and the press priority encoder.
package direction_select_ctrl_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Event vector bit order: [0]=up, [1]=right, [2]=down, [3]=left.
    function automatic logic [1:0] dir_code(input logic [3:0] ev);
        logic [1:0] code;
        code = DIR_LEFT;
        if (ev[0])      code = DIR_UP;
        else if (ev[1]) code = DIR_RIGHT;
        else if (ev[2]) code = DIR_DOWN;
        return code;
    endfunction

endpackage

// File: rtl/direction_select_ctrl_button_debounce.sv
// Per-button 2-flop synchroniser and debouncer; press is a one-cycle pulse
// registered on the cycle the stable level rises.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_stable) begin
                // The flip happens on the edge that would complete the count.
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable <= r_sync2;
                    r_press  <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign stable = r_stable;
    assign press  = r_press;

endmodule

// File: rtl/direction_select_ctrl.sv
// Latches the last pressed direction as select1:select0 for the direction mux.
// Optional AUTO_SCAN_EN adds an idle-triggered auto-scan mode.
module direction_select_ctrl
    import direction_select_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int IDLE_CYCLES     = 4096,
    parameter int SCAN_PERIOD     = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic up,
    input  logic right,
    input  logic down,
    input  logic left,
    output logic select0,
    output logic select1,
    output logic valid,
    output logic sel_change,
    output logic scanning
);

    logic [3:0] w_raw;
    logic [3:0] w_stable;
    logic [3:0] w_press;
    logic [3:0] w_event;
    logic       w_any_event;
    logic [1:0] w_event_code;
    logic       w_scan_step;

    logic [1:0] r_sel;
    logic       r_valid;
    logic       r_sel_change;

    assign w_raw = {left, down, right, up};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk   (clk),
            .reset (reset),
            .raw   (w_raw[g]),
            .stable(w_stable[g]),
            .press (w_press[g])
        );
    end

    assign w_event      = w_press & w_stable;
    assign w_any_event  = |w_event;
    assign w_event_code = dir_code(w_event);

`ifdef AUTO_SCAN_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int SW = $clog2(SCAN_PERIOD + 1);

    mode_e         r_mode;
    mode_e         w_mode_next;
    logic [IW-1:0] r_idle_cnt;
    logic [SW-1:0] r_scan_cnt;
    logic          w_idle;
    logic          w_idle_done;
    logic          w_scanning;

    assign w_idle      = r_valid && (w_stable == 4'b0000);
    assign w_idle_done = w_idle && (r_idle_cnt == IW'(IDLE_CYCLES - 1));
    assign w_scan_step = (r_mode == MODE_SCAN) && (r_scan_cnt == SW'(SCAN_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) r_mode <= MODE_MANUAL;
        else       r_mode <= w_mode_next;
    end

    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            MODE_MANUAL: if (!w_any_event && w_idle_done) w_mode_next = MODE_SCAN;
            MODE_SCAN:   if (w_any_event) w_mode_next = MODE_MANUAL;
            default:     w_mode_next = MODE_MANUAL;
        endcase
    end

    always_comb begin
        w_scanning = (r_mode == MODE_SCAN);
    end

    always_ff @(posedge clk) begin
        if (reset || w_any_event) begin
            r_idle_cnt <= '0;
            r_scan_cnt <= '0;
        end else if (r_mode == MODE_MANUAL) begin
            r_idle_cnt <= (w_idle && !w_idle_done) ? r_idle_cnt + IW'(1) : '0;
            r_scan_cnt <= '0;
        end else begin
            r_idle_cnt <= '0;
            r_scan_cnt <= w_scan_step ? '0 : r_scan_cnt + SW'(1);
        end
    end

    assign scanning = w_scanning;
`else
    assign w_scan_step = 1'b0;
    assign scanning    = 1'b0;
`endif

    // A press always beats a scan step landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel        <= DIR_UP;
            r_valid      <= 1'b0;
            r_sel_change <= 1'b0;
        end else if (w_any_event) begin
            r_sel        <= w_event_code;
            r_valid      <= 1'b1;
            r_sel_change <= (w_event_code != r_sel);
        end else if (w_scan_step) begin
            r_sel        <= r_sel + 2'd1;
            r_sel_change <= 1'b1;
        end else begin
            r_sel_change <= 1'b0;
        end
    end

    assign select0    = r_sel[0];
    assign select1    = r_sel[1];
    assign valid      = r_valid;
    assign sel_change = r_sel_change;

endmodule
